// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature encoder bank: AB state codes, decoded step
// encoding, the {prev, curr} step decoder and a signed saturation helper.
package quad_pkg;

  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S10 = 2'b10;

  // Working width of the saturation helper; wide enough for any COUNT_W in use.
  localparam int unsigned SatW = 64;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_FWD,
    STEP_REV,
    STEP_ERR
  } step_e;

  // Forward order is 00 -> 01 -> 11 -> 10 -> 00 on {A,B}.
  function automatic step_e ab_step(input logic [1:0] prev, input logic [1:0] curr);
    logic [1:0] fwd;
    case (prev)
      S00:     fwd = S01;
      S01:     fwd = S11;
      S11:     fwd = S10;
      default: fwd = S00;
    endcase
    if (prev == curr) begin
      return STEP_NONE;
    end else if ((prev ^ curr) == 2'b11) begin
      return STEP_ERR;
    end else if (curr == fwd) begin
      return STEP_FWD;
    end else begin
      return STEP_REV;
    end
  endfunction

  // Clamp a signed value to the range of a w-bit two's-complement number.
  function automatic logic signed [SatW-1:0] sat_signed(input logic signed [SatW-1:0] v,
                                                        input int unsigned w);
    logic signed [SatW-1:0] hi;
    logic signed [SatW-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/quad_channel.sv
// One encoder channel: 2-FF sync, per-input stability filter, x4 decode, wrapping count and
// sticky illegal-transition flag. Index capture is built when QUAD_ENCODER_BANK_INDEX_EN is set.
module quad_channel
  import quad_pkg::*;
#(
  parameter int unsigned COUNT_W       = 24,
  parameter int unsigned FILTER_CYCLES = 100
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               quad_a,
  input  logic               quad_b,
`ifdef QUAD_ENCODER_BANK_INDEX_EN
  input  logic               index,
  output logic [COUNT_W-1:0] index_position,
  output logic               index_seen,
`endif
  input  logic               clear,
  input  logic               error_clr,
  output logic [COUNT_W-1:0] count,
  output logic               error
);

`ifdef QUAD_ENCODER_BANK_INDEX_EN
  localparam int unsigned NumIn = 3;
  logic [NumIn-1:0] raw;
  assign raw = {index, quad_a, quad_b};
`else
  localparam int unsigned NumIn = 2;
  logic [NumIn-1:0] raw;
  assign raw = {quad_a, quad_b};
`endif

  localparam int unsigned FiltW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER_CYCLES - 1);

  logic [NumIn-1:0] sync1_q, sync2_q;
  logic [NumIn-1:0] filt_q, filt_d, filt_prev_q;
  logic [FiltW-1:0] fcnt_q [NumIn];
  logic [FiltW-1:0] fcnt_d [NumIn];
  logic             init_q;
  logic [COUNT_W-1:0] count_q, count_d;
  logic             error_q, error_d;
  step_e            step;

  // Synchronisers track the pins through reset so the post-reset reload sees the true level.
  always_ff @(posedge CLK) begin
    sync1_q <= raw;
    sync2_q <= sync1_q;
  end

  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < int'(NumIn); i++) begin
      fcnt_d[i] = '0;
      if (init_q) begin
        filt_d[i] = sync2_q[i];
      end else if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FiltLast) begin
          filt_d[i] = sync2_q[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign step = init_q ? STEP_NONE : ab_step(filt_prev_q[1:0], filt_q[1:0]);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else begin
      case (step)
        STEP_FWD: count_d = count_q + COUNT_W'(1);
        STEP_REV: count_d = count_q - COUNT_W'(1);
        default:  count_d = count_q;
      endcase
    end
  end

  // A new illegal transition outranks error_clr.
  always_comb begin
    error_d = error_q;
    if (step == STEP_ERR) begin
      error_d = 1'b1;
    end else if (error_clr) begin
      error_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      init_q      <= 1'b1;
      filt_q      <= '0;
      filt_prev_q <= '0;
      fcnt_q      <= '{default: '0};
      count_q     <= '0;
      error_q     <= 1'b0;
    end else begin
      init_q      <= 1'b0;
      filt_q      <= filt_d;
      // On the reload cycle prev follows the reloaded level so no step is decoded.
      filt_prev_q <= init_q ? filt_d : filt_q;
      fcnt_q      <= fcnt_d;
      count_q     <= count_d;
      error_q     <= error_d;
    end
  end

  assign count = count_q;
  assign error = error_q;

`ifdef QUAD_ENCODER_BANK_INDEX_EN
  logic               idx_rise;
  logic [COUNT_W-1:0] idx_pos_q, idx_pos_d;
  logic               idx_seen_q, idx_seen_d;

  assign idx_rise = ~init_q & filt_q[2] & ~filt_prev_q[2];

  always_comb begin
    idx_pos_d  = idx_pos_q;
    idx_seen_d = idx_seen_q;
    if (idx_rise) begin
      idx_pos_d = count_d;
    end
    if (clear) begin
      idx_seen_d = 1'b0;
    end else if (idx_rise) begin
      idx_seen_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      idx_pos_q  <= '0;
      idx_seen_q <= 1'b0;
    end else begin
      idx_pos_q  <= idx_pos_d;
      idx_seen_q <= idx_seen_d;
    end
  end

  assign index_position = idx_pos_q;
  assign index_seen     = idx_seen_q;
`endif

endmodule

// File: rtl/quad_encoder_bank.sv
// N-channel quadrature encoder front end with shared velocity window.
// Define QUAD_ENCODER_BANK_INDEX_EN to add index inputs, index_position and index_seen.
module quad_encoder_bank
  import quad_pkg::*;
#(
  parameter int unsigned CHANNELS      = 2,
  parameter int unsigned COUNT_W       = 24,
  parameter int unsigned FILTER_CYCLES = 100,
  parameter int unsigned VEL_WINDOW    = 32000,
  parameter int unsigned VEL_W         = 16
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic [CHANNELS-1:0]           quadA,
  input  logic [CHANNELS-1:0]           quadB,
  input  logic [CHANNELS-1:0]           clear,
  input  logic                          error_clr,
`ifdef QUAD_ENCODER_BANK_INDEX_EN
  input  logic [CHANNELS-1:0]           index,
  output logic [CHANNELS*COUNT_W-1:0]   index_position,
  output logic [CHANNELS-1:0]           index_seen,
`endif
  output logic [CHANNELS*COUNT_W-1:0]   count,
  output logic [CHANNELS*VEL_W-1:0]     velocity,
  output logic                          vel_valid,
  output logic [CHANNELS-1:0]           error
);

  localparam int unsigned WinW = $clog2(VEL_WINDOW);

  logic [WinW-1:0] win_q, win_d;
  logic            win_tc;
  logic            vel_valid_q;

  assign win_tc = (win_q == WinW'(VEL_WINDOW - 1));
  assign win_d  = win_tc ? '0 : win_q + WinW'(1);

  always_ff @(posedge CLK) begin
    if (reset) begin
      win_q       <= '0;
      vel_valid_q <= 1'b0;
    end else begin
      win_q       <= win_d;
      vel_valid_q <= win_tc;
    end
  end

  assign vel_valid = vel_valid_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [COUNT_W-1:0] cnt;
    logic [COUNT_W-1:0] snap_q, snap_d;
    logic [COUNT_W-1:0] delta;
    logic [VEL_W-1:0]   vel_q, vel_d;

    quad_channel #(
      .COUNT_W       (COUNT_W),
      .FILTER_CYCLES (FILTER_CYCLES)
    ) u_channel (
      .CLK            (CLK),
      .reset          (reset),
      .quad_a         (quadA[g]),
      .quad_b         (quadB[g]),
`ifdef QUAD_ENCODER_BANK_INDEX_EN
      .index          (index[g]),
      .index_position (index_position[g*COUNT_W +: COUNT_W]),
      .index_seen     (index_seen[g]),
`endif
      .clear          (clear[g]),
      .error_clr      (error_clr),
      .count          (cnt),
      .error          (error[g])
    );

    // Modular subtraction keeps the delta right across a count wrap.
    assign delta = cnt - snap_q;

    always_comb begin
      snap_d = snap_q;
      vel_d  = vel_q;
      if (win_tc) begin
        vel_d  = VEL_W'(sat_signed(SatW'($signed(delta)), VEL_W));
        snap_d = cnt;
      end
      if (clear[g]) begin
        snap_d = '0;
        if (win_tc) begin
          vel_d = '0;
        end
      end
    end

    always_ff @(posedge CLK) begin
      if (reset) begin
        snap_q <= '0;
        vel_q  <= '0;
      end else begin
        snap_q <= snap_d;
        vel_q  <= vel_d;
      end
    end

    assign count[g*COUNT_W +: COUNT_W] = cnt;
    assign velocity[g*VEL_W +: VEL_W]  = vel_q;
  end

endmodule

// File: tb/tb_quad_encoder_bank.sv
// Self-checking bench for quad_encoder_bank: a wide instance (24-bit count, 16-bit velocity)
// and a narrow one (8-bit count, 4-bit velocity) for wrap and saturation cases.
module tb_quad_encoder_bank;

  localparam int CH  = 2;
  localparam int CW  = 24;
  localparam int VW  = 16;
  localparam int SCW = 8;
  localparam int SVW = 4;
  localparam int FC  = 4;
  localparam int WIN = 64;

  typedef struct {
    bit sm;
    int ch;
    int val;
  } vel_exp_t;

  vel_exp_t vel_q[$];

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic              reset;
  logic              error_clr;
  logic [CH-1:0]     quadA, quadB, clear, sA, sB, sclear;
  logic [CH*CW-1:0]  count;
  logic [CH*VW-1:0]  velocity;
  logic              vel_valid;
  logic [CH-1:0]     error;
  logic [CH*SCW-1:0] s_count;
  logic [CH*SVW-1:0] s_velocity;
  logic              s_vel_valid;
  logic [CH-1:0]     s_error;
`ifdef QUAD_ENCODER_BANK_INDEX_EN
  logic [CH-1:0]     index, s_index, index_seen, s_index_seen;
  logic [CH*CW-1:0]  index_position;
  logic [CH*SCW-1:0] s_index_position;
`endif

  int tests = 0;
  int fails = 0;
  int exp_m[CH];
  int exp_s[CH];
  logic [1:0] ab_m[CH];
  logic [1:0] ab_s[CH];

  quad_encoder_bank #(
    .CHANNELS(CH), .COUNT_W(CW), .FILTER_CYCLES(FC), .VEL_WINDOW(WIN), .VEL_W(VW)
  ) u_dut (
    .CLK            (CLK),
    .reset          (reset),
    .quadA          (quadA),
    .quadB          (quadB),
    .clear          (clear),
    .error_clr      (error_clr),
`ifdef QUAD_ENCODER_BANK_INDEX_EN
    .index          (index),
    .index_position (index_position),
    .index_seen     (index_seen),
`endif
    .count          (count),
    .velocity       (velocity),
    .vel_valid      (vel_valid),
    .error          (error)
  );

  quad_encoder_bank #(
    .CHANNELS(CH), .COUNT_W(SCW), .FILTER_CYCLES(FC), .VEL_WINDOW(WIN), .VEL_W(SVW)
  ) u_small (
    .CLK            (CLK),
    .reset          (reset),
    .quadA          (sA),
    .quadB          (sB),
    .clear          (sclear),
    .error_clr      (error_clr),
`ifdef QUAD_ENCODER_BANK_INDEX_EN
    .index          (s_index),
    .index_position (s_index_position),
    .index_seen     (s_index_seen),
`endif
    .count          (s_count),
    .velocity       (s_velocity),
    .vel_valid      (s_vel_valid),
    .error          (s_error)
  );

  function automatic logic [CW-1:0] cnt_m(input int ch);
    return count[ch*CW +: CW];
  endfunction
  function automatic logic [VW-1:0] vel_m(input int ch);
    return velocity[ch*VW +: VW];
  endfunction
  function automatic logic [SCW-1:0] cnt_s(input int ch);
    return s_count[ch*SCW +: SCW];
  endfunction
  function automatic logic [SVW-1:0] vel_s(input int ch);
    return s_velocity[ch*SVW +: SVW];
  endfunction

  function automatic logic [1:0] next_ab(input logic [1:0] ab, input bit fwd);
    case (ab)
      2'b00:   return fwd ? 2'b01 : 2'b10;
      2'b01:   return fwd ? 2'b11 : 2'b00;
      2'b11:   return fwd ? 2'b10 : 2'b01;
      default: return fwd ? 2'b00 : 2'b11;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drive_step(input bit sm, input int ch, input bit fwd);
    if (sm) begin
      ab_s[ch]  = next_ab(ab_s[ch], fwd);
      sA[ch]    = ab_s[ch][1];
      sB[ch]    = ab_s[ch][0];
      exp_s[ch] += fwd ? 1 : -1;
    end else begin
      ab_m[ch]  = next_ab(ab_m[ch], fwd);
      quadA[ch] = ab_m[ch][1];
      quadB[ch] = ab_m[ch][0];
      exp_m[ch] += fwd ? 1 : -1;
    end
  endtask

  task automatic steps(input bit sm, input int ch, input bit fwd, input int n, input int hold);
    for (int i = 0; i < n; i++) begin
      drive_step(sm, ch, fwd);
      tick(hold);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    for (int i = 0; i < CH; i++) begin
      exp_m[i] = 0;
      exp_s[i] = 0;
    end
    vel_q.delete();
  endtask

  // Waits for the next vel_valid pulse and checks every queued velocity expectation.
  task automatic wait_vel(input bit sm);
    int  n;
    bit  seen;
    int  got;
    vel_exp_t e;
    seen = 1'b0;
    for (n = 0; n < 200 && !seen; n++) begin
      tick(1);
      seen = sm ? s_vel_valid : vel_valid;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL vel_valid_timeout: no vel_valid within %0d cycles", n);
      vel_q.delete();
    end else begin
      while (vel_q.size() > 0) begin
        e = vel_q.pop_front();
        if (e.sm) got = int'($signed(vel_s(e.ch)));
        else      got = int'($signed(vel_m(e.ch)));
        tests++;
        if (got !== e.val) begin
          fails++;
          $display("FAIL velocity sm=%0d ch=%0d: got %0d expected %0d", e.sm, e.ch, got, e.val);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(4);
    tests++;
    if (count !== '0 || velocity !== '0 || vel_valid !== 1'b0 || error !== '0) begin
      fails++;
      $display("FAIL reset_outputs: count=%h vel=%h vv=%b err=%b expected all 0",
               count, velocity, vel_valid, error);
    end
    tests++;
    if (s_count !== '0 || s_velocity !== '0 || s_error !== '0) begin
      fails++;
      $display("FAIL reset_small: count=%h vel=%h err=%b expected 0", s_count, s_velocity, s_error);
    end
`ifdef QUAD_ENCODER_BANK_INDEX_EN
    tests++;
    if (index_seen !== '0 || index_position !== '0) begin
      fails++;
      $display("FAIL reset_index: seen=%b pos=%h expected 0", index_seen, index_position);
    end
`endif
    do_reset();
    tick(63);
    tests++;
    if (vel_valid !== 1'b0) begin
      fails++;
      $display("FAIL vel_valid_early: got %b expected 0", vel_valid);
    end
    tick(1);
    tests++;
    if (vel_valid !== 1'b1 || velocity !== '0) begin
      fails++;
      $display("FAIL first_vel_valid: vv=%b vel=%h expected 1 and 0", vel_valid, velocity);
    end
    // Reset while a filter is part-way through accepting a new level.
    drive_step(0, 0, 1'b1);
    tick(3);
    do_reset();
    tick(20);
    tests++;
    if (cnt_m(0) !== '0 || error !== '0) begin
      fails++;
      $display("FAIL reset_midop: count0=%h err=%b expected 0 and 0", cnt_m(0), error);
    end
  endtask

  task automatic test_forward();
    for (int i = 0; i < 8; i++) begin
      drive_step(0, 0, 1'b1);
      tick(6);
      tests++;
      if (cnt_m(0) !== CW'(exp_m[0] - 1)) begin
        fails++;
        $display("FAIL fwd_early step%0d: got %0d expected %0d", i, cnt_m(0), exp_m[0] - 1);
      end
      tick(1);
      tests++;
      if (cnt_m(0) !== CW'(exp_m[0])) begin
        fails++;
        $display("FAIL fwd_land step%0d: got %0d expected %0d", i, cnt_m(0), exp_m[0]);
      end
      tick(3);
    end
    tests++;
    if (cnt_m(0) !== CW'(8) || cnt_m(1) !== '0) begin
      fails++;
      $display("FAIL fwd_total: count0=%0d count1=%0d expected 8 and 0", cnt_m(0), cnt_m(1));
    end
  endtask

  task automatic test_glitch();
    quadA[1] = 1'b1;
    tick(3);
    quadA[1] = 1'b0;
    tick(10);
    tests++;
    if (cnt_m(1) !== '0 || error[1] !== 1'b0) begin
      fails++;
      $display("FAIL glitch_3cyc: count1=%h err1=%b expected 0 and 0", cnt_m(1), error[1]);
    end
    quadA[1] = 1'b1;
    tick(4);
    quadA[1] = 1'b0;
    tick(3);
    tests++;
    if (cnt_m(1) !== CW'(-1)) begin
      fails++;
      $display("FAIL glitch_4cyc: count1=%h expected %h", cnt_m(1), CW'(-1));
    end
    tick(10);
    tests++;
    if (cnt_m(1) !== '0 || error[1] !== 1'b0) begin
      fails++;
      $display("FAIL glitch_return: count1=%h err1=%b expected 0 and 0", cnt_m(1), error[1]);
    end
  endtask

  task automatic test_illegal();
    ab_m[0] ^= 2'b11;
    quadA[0] = ab_m[0][1];
    quadB[0] = ab_m[0][0];
    tick(7);
    tests++;
    if (cnt_m(0) !== CW'(exp_m[0]) || error !== 2'b01) begin
      fails++;
      $display("FAIL illegal_set: count0=%0d err=%b expected %0d and 01", cnt_m(0), error, exp_m[0]);
    end
    tick(5);
    tests++;
    if (error[0] !== 1'b1) begin
      fails++;
      $display("FAIL illegal_sticky: err0=%b expected 1", error[0]);
    end
    error_clr = 1'b1;
    tick(1);
    error_clr = 1'b0;
    tests++;
    if (error[0] !== 1'b0) begin
      fails++;
      $display("FAIL error_clr: err0=%b expected 0", error[0]);
    end
    ab_m[0] ^= 2'b11;
    quadA[0] = ab_m[0][1];
    quadB[0] = ab_m[0][0];
    tick(6);
    error_clr = 1'b1;
    tick(1);
    error_clr = 1'b0;
    tests++;
    if (error[0] !== 1'b1 || cnt_m(0) !== CW'(exp_m[0])) begin
      fails++;
      $display("FAIL illegal_vs_clr: err0=%b count0=%0d expected 1 and %0d",
               error[0], cnt_m(0), exp_m[0]);
    end
  endtask

  task automatic test_wrap_velocity();
    do_reset();
    steps(0, 0, 1'b0, 3, 10);
    vel_q.push_back('{sm: 1'b0, ch: 0, val: -3});
    vel_q.push_back('{sm: 1'b0, ch: 1, val: 0});
    wait_vel(1'b0);
    steps(0, 0, 1'b1, 5, 8);
    vel_q.push_back('{sm: 1'b0, ch: 0, val: 5});
    wait_vel(1'b0);
    tests++;
    if (cnt_m(0) !== CW'(2)) begin
      fails++;
      $display("FAIL preload_count: got %0d expected 2", cnt_m(0));
    end
  endtask

  task automatic test_small();
    do_reset();
    steps(1, 0, 1'b1, 125, 5);
    tick(10);
    wait_vel(1'b1);
    for (int i = 0; i < 4; i++) begin
      drive_step(1, 0, 1'b1);
      tick(8);
      tests++;
      if (cnt_s(0) !== SCW'(exp_s[0])) begin
        fails++;
        $display("FAIL wrap8 step%0d: got %h expected %h", i, cnt_s(0), SCW'(exp_s[0]));
      end
    end
    vel_q.push_back('{sm: 1'b1, ch: 0, val: 4});
    wait_vel(1'b1);
    steps(1, 0, 1'b1, 10, 5);
    vel_q.push_back('{sm: 1'b1, ch: 0, val: 7});
    wait_vel(1'b1);
    steps(1, 0, 1'b0, 10, 5);
    vel_q.push_back('{sm: 1'b1, ch: 0, val: -8});
    wait_vel(1'b1);
    // Assert clear exactly on the terminal-count cycle of the following window.
    steps(1, 0, 1'b1, 3, 8);
    tick(39);
    sclear[0] = 1'b1;
    tick(1);
    sclear[0] = 1'b0;
    exp_s[0] = 0;
    tests++;
    if (s_vel_valid !== 1'b1 || vel_s(0) !== '0 || cnt_s(0) !== '0) begin
      fails++;
      $display("FAIL clear_at_tc: vv=%b vel0=%h count0=%h expected 1, 0, 0",
               s_vel_valid, vel_s(0), cnt_s(0));
    end
    vel_q.push_back('{sm: 1'b1, ch: 0, val: 0});
    wait_vel(1'b1);
  endtask

`ifdef QUAD_ENCODER_BANK_INDEX_EN
  task automatic test_index();
    do_reset();
    steps(0, 0, 1'b1, 42, 5);
    tick(10);
    index[0] = 1'b1;
    tick(12);
    tests++;
    if (index_position[0 +: CW] !== CW'(42) || index_seen !== 2'b01) begin
      fails++;
      $display("FAIL index_capture: pos0=%0d seen=%b expected 42 and 01",
               index_position[0 +: CW], index_seen);
    end
    index[0] = 1'b0;
    tick(10);
    clear[0] = 1'b1;
    tick(1);
    clear[0] = 1'b0;
    exp_m[0] = 0;
    tests++;
    if (index_seen[0] !== 1'b0 || cnt_m(0) !== '0) begin
      fails++;
      $display("FAIL index_clear: seen0=%b count0=%0d expected 0 and 0", index_seen[0], cnt_m(0));
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    error_clr = 1'b0;
    quadA     = '0;
    quadB     = '0;
    clear     = '0;
    sA        = '0;
    sB        = '0;
    sclear    = '0;
`ifdef QUAD_ENCODER_BANK_INDEX_EN
    index     = '0;
    s_index   = '0;
`endif
    for (int i = 0; i < CH; i++) begin
      ab_m[i]  = 2'b00;
      ab_s[i]  = 2'b00;
      exp_m[i] = 0;
      exp_s[i] = 0;
    end
    test_reset();
    test_forward();
    test_glitch();
    test_illegal();
    test_wrap_velocity();
    test_small();
`ifdef QUAD_ENCODER_BANK_INDEX_EN
    test_index();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/quad_encoder_bank.md
Name: quad_encoder_bank

Overview:
- N-channel quadrature encoder front end; next generation of the single-channel quad counter on the motor board.
- Per channel: input synchronisation, a glitch filter, x4 decoding, wrapping position count, sticky illegal-transition flag and windowed velocity estimate.
- Sits between encoder pins and coms/motorControl; count outputs feed motor_state and displacement logic directly.

Parameters:
- CHANNELS, 2, number of independent encoder channels (1..8).
- COUNT_W, 24, signed position counter width.
- FILTER_CYCLES, 100, consecutive stable CLK cycles before a synchronised input level is accepted (>=1).
- VEL_WINDOW, 32000, CLK cycles per velocity window (1 ms at 32 MHz; >=2).
- VEL_W, 16, signed velocity output width (<= COUNT_W).

Ports:
- CLK  in  1  system clock (32 MHz PLL domain).
- reset  in  1  synchronous, active-high reset.
- quadA  in  CHANNELS  raw encoder A inputs, asynchronous.
- quadB  in  CHANNELS  raw encoder B inputs, asynchronous.
- clear  in  CHANNELS  per-channel synchronous count clear.
- error_clr  in  1  clears all sticky error flags.
- count  out  CHANNELS*COUNT_W  signed positions; channel i at [i*COUNT_W +: COUNT_W].
- velocity  out  CHANNELS*VEL_W  signed counts per window; channel i at [i*VEL_W +: VEL_W].
- vel_valid  out  1  one-cycle pulse when velocity updates.
- error  out  CHANNELS  sticky illegal-transition flag.

Behaviour:
- Interface: single clock CLK; reset is synchronous and active-high. Every output resets to 0. Filter state, decoder state, window counter and snapshots also reset. The filtered AB state reloads from the current synchroniser output on the first cycle after reset; that reload produces no count.
- Sync: 2-FF synchroniser per raw input.
- Filter: per-input stability counter. An accepted level changes only after FILTER_CYCLES consecutive identical synchronised samples that differ from the current accepted level. Any mismatch restarts the count.
- Decode on filtered {A,B}, registered:
  - Forward sequence 00->01->11->10->00: count +1.
  - Reverse sequence: count -1.
  - No change: hold.
  - Both bits change in one cycle: no count change, error[i] <= 1.
- Latency: raw edge to count update = 2 (sync) + FILTER_CYCLES + 1 cycles.
- Count arithmetic: two's-complement wrap (0x7FFFFF +1 -> 0x800000 at COUNT_W=24). No saturation.
- clear[i]: count[i] <= 0 and snapshot[i] <= 0 next cycle. clear wins over a simultaneous step.
- error_clr: clears all flags. A simultaneous new illegal transition wins, so the flag stays 1.
- Velocity:
  - A shared window counter runs 0..VEL_WINDOW-1.
  - At terminal count, per channel: delta = count - snapshot, computed in COUNT_W modular arithmetic so that wrap is correct.
  - The delta is saturated to the VEL_W signed range, written to velocity, and snapshot <= count. vel_valid pulses on that same registered cycle.
  - If clear coincides with the terminal count, velocity <= 0 and snapshot <= 0.
  - The first vel_valid after reset occurs VEL_WINDOW cycles after reset deasserts.
- Reset mid-operation: all state is discarded, including partial filter counts; no spurious count is produced.

Optional Feature:
- Macro QUAD_ENCODER_BANK_INDEX_EN.
- Defined:
  - Adds index (in, CHANNELS), index_position (out, CHANNELS*COUNT_W) and index_seen (out, CHANNELS).
  - index passes through the same sync and filter path.
  - A rising edge on the filtered index captures the current count (post-update value that cycle) into index_position[i] and sets index_seen[i].
  - index_seen clears on clear[i]; it also resets to 0.
- Undefined: these ports and their logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package quad_pkg:
  - AB state constants S00/S01/S11/S10.
  - Step encoding (STEP_NONE, STEP_FWD, STEP_REV, STEP_ERR).
  - A function mapping {prev, curr} to a step.
  - A saturate-to-width function.
- Sub-module quad_channel: sync + filter + decode + count + error for one channel; instantiated CHANNELS times in a generate loop.
- The top level owns the window counter, snapshots, velocity saturation and vel_valid.

Test Plan:
- Use FILTER_CYCLES=4, VEL_WINDOW=64, CHANNELS=2 throughout.
- Forward steps: 8 forward steps on ch0, each level held 10 cycles -> count0=8, count1=0; each update lands 7 cycles after its edge.
- Glitch rejection: a 3-cycle pulse on quadA[1] -> count1 unchanged and error[1]=0. The same pulse held 4 cycles is accepted as a step.
- Illegal transition: A and B toggled in the same cycle on ch0 -> count unchanged and error[0]=1. The flag persists until error_clr; error_clr asserted together with a new illegal step leaves it 1.
- Wrap and velocity: preload via reverse steps from 0 to -3, then 5 forward steps inside one window -> count=2 and velocity=+5 at the next vel_valid. With COUNT_W=8, stepping from 127 forward gives -128, and velocity stays correct.
- Velocity saturation: VEL_W=4 with 10 forward steps in one window -> velocity=7. clear[0] on the terminal-count cycle -> count0=0, velocity0=0.
- Index feature (QUAD_ENCODER_BANK_INDEX_EN): index pulse at count=42 -> index_position0=42 and index_seen0=1. A following clear[0] -> index_seen0=0.
